// File: rtl/esp8266_link_ctrl.sv
// esp8266_link_ctrl: ESP8266 AT bring-up sequencer with reply check, timeout/retry and app TX handoff.
// Optional macro ESP_ATE0_EN prepends "ATE0\r\n" as command 0.  Rev 1.0
`default_nettype none

module esp8266_link_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       tx_busy,
  output logic       tx_wrsig,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       app_req,
  input  logic [7:0] app_data,
  output logic       app_ack,
  output logic       link_up,
  output logic       link_err,
  output logic [2:0] cmd_idx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_WAIT_OK = 3'd3,
    S_READY   = 3'd4,
    S_APP_TX  = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

`ifdef ESP_ATE0_EN
  localparam logic [2:0] LAST_CMD = 3'd4;
`else
  localparam logic [2:0] LAST_CMD = 3'd3;
`endif

  // Command strings are left-aligned in a 21-byte field so byte p sits at the top after a shift.
  function automatic logic [167:0] cmd_str(input logic [2:0] idx);
    case (idx)
`ifdef ESP_ATE0_EN
      3'd0:    return {"ATE0\r\n", {15{8'h00}}};
      3'd1:    return {"AT\r\n", {17{8'h00}}};
      3'd2:    return {"AT+CWMODE=2\r\n", {8{8'h00}}};
      3'd3:    return {"AT+CIPMUX=1\r\n", {8{8'h00}}};
`else
      3'd0:    return {"AT\r\n", {17{8'h00}}};
      3'd1:    return {"AT+CWMODE=2\r\n", {8{8'h00}}};
      3'd2:    return {"AT+CIPMUX=1\r\n", {8{8'h00}}};
`endif
      default: return "AT+CIPSERVER=1,8080\r\n";
    endcase
  endfunction

  function automatic logic [4:0] cmd_len(input logic [2:0] idx);
    case (idx)
`ifdef ESP_ATE0_EN
      3'd0:    return 5'd6;
      3'd1:    return 5'd4;
      3'd2:    return 5'd13;
      3'd3:    return 5'd13;
`else
      3'd0:    return 5'd4;
      3'd1:    return 5'd13;
      3'd2:    return 5'd13;
`endif
      default: return 5'd21;
    endcase
  endfunction

  function automatic logic [7:0] rom_byte(input logic [2:0] idx, input logic [4:0] p);
    logic [167:0] s;
    s = cmd_str(idx) << {p, 3'b000};
    return s[167:160];
  endfunction

  state_t      state, state_next;
  logic [4:0]  ptr;
  logic [1:0]  retry;
  logic        busy_seen;
  logic [7:0]  hist;
  logic [23:0] tmo_cnt;

  logic ok_hit, err_hit, tmo_hit, tx_done, last_byte, retry_left, last_cmd, app_go;

  assign ok_hit     = (state == S_WAIT_OK) && rx_valid && (hist == 8'h4F) && (rx_data == 8'h4B);
  assign err_hit    = (state == S_WAIT_OK) && rx_valid && (hist == 8'h45) && (rx_data == 8'h52);
  assign tmo_hit    = (state == S_WAIT_OK) && (tmo_cnt == TIMEOUT_CYC - 24'd1);
  assign tx_done    = busy_seen && !tx_busy;
  assign last_byte  = (ptr == cmd_len(cmd_idx) - 5'd1);
  assign retry_left = ({1'b0, retry} + 3'd1) < {1'b0, MAX_RETRY};
  assign last_cmd   = (cmd_idx == LAST_CMD);
  assign app_go     = app_req && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!tx_busy) state_next = S_SEND;
      S_SEND:    state_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_done) state_next = last_byte ? S_WAIT_OK : S_SEND;
      S_WAIT_OK: begin
        // An OK landing on the timeout cycle still counts as success.
        if (ok_hit)                  state_next = last_cmd ? S_READY : S_IDLE;
        else if (err_hit || tmo_hit) state_next = retry_left ? S_IDLE : S_FAIL;
      end
      S_READY:   if (app_go) state_next = S_APP_TX;
      S_APP_TX:  if (tx_done) state_next = S_READY;
      S_FAIL:    state_next = S_FAIL;
      default:   state_next = S_IDLE;
    endcase
    if (restart) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wrsig  <= 1'b0;
      tx_data   <= 8'h00;
      app_ack   <= 1'b0;
      link_up   <= 1'b0;
      link_err  <= 1'b0;
      cmd_idx   <= 3'd0;
      ptr       <= 5'd0;
      retry     <= 2'd0;
      busy_seen <= 1'b0;
      hist      <= 8'h00;
      tmo_cnt   <= 24'd0;
    end else begin
      tx_wrsig <= 1'b0;
      app_ack  <= 1'b0;
      if (restart) begin
        link_up   <= 1'b0;
        link_err  <= 1'b0;
        cmd_idx   <= 3'd0;
        ptr       <= 5'd0;
        retry     <= 2'd0;
        busy_seen <= 1'b0;
        hist      <= 8'h00;
        tmo_cnt   <= 24'd0;
      end else begin
        case (state)
          S_SEND: begin
            tx_wrsig  <= 1'b1;
            tx_data   <= rom_byte(cmd_idx, ptr);
            busy_seen <= 1'b0;
          end
          S_WAIT_TX: begin
            if (tx_busy) busy_seen <= 1'b1;
            if (tx_done) begin
              if (last_byte) begin
                hist    <= 8'h00;
                tmo_cnt <= 24'd0;
              end else begin
                ptr <= ptr + 5'd1;
              end
            end
          end
          S_WAIT_OK: begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (rx_valid) hist <= rx_data;
            if (ok_hit) begin
              ptr   <= 5'd0;
              retry <= 2'd0;
              if (last_cmd) link_up <= 1'b1;
              else          cmd_idx <= cmd_idx + 3'd1;
            end else if (err_hit || tmo_hit) begin
              ptr <= 5'd0;
              if (retry_left) retry    <= retry + 2'd1;
              else            link_err <= 1'b1;
            end
          end
          S_READY: begin
            if (app_go) begin
              tx_wrsig  <= 1'b1;
              tx_data   <= app_data;
              app_ack   <= 1'b1;
              busy_seen <= 1'b0;
            end
          end
          S_APP_TX: begin
            if (tx_busy) busy_seen <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_esp8266_link_ctrl.sv
// tb_esp8266_link_ctrl: directed bench with a uart_tx busy stub and an auto-replying ESP8266 model.
`default_nettype none

module tb_esp8266_link_ctrl;

`ifdef ESP_ATE0_EN
  localparam int NCMD = 5;
`else
  localparam int NCMD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n, restart, tx_busy, tx_wrsig, rx_valid, app_req, app_ack;
  logic       link_up, link_err;
  logic [7:0] tx_data, rx_data, app_data;
  logic [2:0] cmd_idx;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  esp8266_link_ctrl #(.TIMEOUT_CYC(24'd100), .MAX_RETRY(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .tx_busy(tx_busy),
    .tx_wrsig(tx_wrsig), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .app_req(app_req), .app_data(app_data), .app_ack(app_ack),
    .link_up(link_up), .link_err(link_err), .cmd_idx(cmd_idx)
  );

  function automatic string cmd_str(int k);
`ifdef ESP_ATE0_EN
    case (k)
      0: return "ATE0\r\n";
      1: return "AT\r\n";
      2: return "AT+CWMODE=2\r\n";
      3: return "AT+CIPMUX=1\r\n";
      default: return "AT+CIPSERVER=1,8080\r\n";
    endcase
`else
    case (k)
      0: return "AT\r\n";
      1: return "AT+CWMODE=2\r\n";
      2: return "AT+CIPMUX=1\r\n";
      default: return "AT+CIPSERVER=1,8080\r\n";
    endcase
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx stub: busy for 10 cycles after each load strobe
  int busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              busy_cnt <= 0;
    else if (tx_wrsig)       busy_cnt <= 10;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Strobe log and protocol monitor
  logic [7:0] tx_log[$];
  logic [2:0] idx_log[$];
  int   ack_cnt = 0;
  int   prot_viol = 0;
  logic prev_wr = 1'b0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (tx_wrsig) begin
        tx_log.push_back(tx_data);
        idx_log.push_back(cmd_idx);
      end
      if (app_ack) ack_cnt <= ack_cnt + 1;
      prot_viol <= prot_viol + int'(tx_wrsig && tx_busy) + int'(tx_wrsig && prev_wr)
                             + int'(app_ack && !tx_wrsig);
      prev_wr <= tx_wrsig;
    end
  end

  function automatic int count_idx(int base, int k);
    int n = 0;
    for (int i = base; i < idx_log.size(); i++)
      if (int'(idx_log[i]) == k) n++;
    return n;
  endfunction

  // ESP8266 reply model: reacts to the '\n' closing each command
  int err_cmd    = 7;
  int silent_cmd = 7;
  bit err_used   = 1'b0;

  task automatic send_rx(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cap;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst_n && tx_wrsig && tx_data == 8'h0a) begin
        cap = int'(cmd_idx);
        repeat (15) @(posedge clk);
        #1;
        if (cap == err_cmd && !err_used) begin
          err_used = 1'b1;
          send_rx("ERROR\r\n");
        end else if (cap != silent_cmd) begin
          send_rx("OK\r\n");
        end
      end
    end
  end

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic wait_link_up(input string tag, input bit chk_lat);
    bit done = 1'b0;
    bit prev_k = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (link_up) begin
        done = 1'b1;
        if (chk_lat) check("link_up_after_K", {31'd0, prev_k}, 32'd1);
      end
      prev_k = rx_valid && (rx_data == 8'h4B);
    end
    check({tag, "_link_up_bound"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base, total, mism, k;
    bit done;
    string s;
    rst_n = 1'b0; restart = 1'b0; app_req = 1'b0; app_data = 8'h00;

    // Reset values and first-strobe latency
    repeat (3) @(negedge clk);
    check("rst_tx_wrsig", {31'd0, tx_wrsig}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);
    check("rst_app_ack",  {31'd0, app_ack},  32'd0);
    check("rst_link_up",  {31'd0, link_up},  32'd0);
    check("rst_link_err", {31'd0, link_err}, 32'd0);
    check("rst_cmd_idx",  {29'd0, cmd_idx},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("edge1_no_strobe", {31'd0, tx_wrsig}, 32'd0);
    @(negedge clk);
    check("edge2_strobe", {31'd0, tx_wrsig}, 32'd1);

    // Full bring-up with OK replies
    wait_link_up("t1", 1'b1);
    total = 0; mism = 0; k = 0;
    for (int c = 0; c < NCMD; c++) begin
      s = cmd_str(c);
      for (int j = 0; j < s.len(); j++) begin
        if (k < tx_log.size() && tx_log[k] !== s[j]) mism++;
        k++;
      end
      total += s.len();
      check($sformatf("t1_strobes_idx%0d", c), count_idx(0, c), s.len());
    end
    check("t1_strobe_total", tx_log.size(), total);
    check("t1_rom_bytes", mism, 0);
    check("t1_cmd_idx_last", {29'd0, cmd_idx}, NCMD - 1);
    check("t1_link_err", {31'd0, link_err}, 32'd0);

    // ERROR once on the CWMODE command, then OK
    err_cmd = NCMD - 3;
    base = tx_log.size();
    pulse_restart();
    check("t2_link_up_cleared", {31'd0, link_up}, 32'd0);
    wait_link_up("t2", 1'b0);
    check("t2_err_sent", {31'd0, err_used}, 32'd1);
    check("t2_cwmode_twice", count_idx(base, NCMD - 3), 2 * cmd_str(NCMD - 3).len());
    check("t2_strobe_total", tx_log.size() - base, total + cmd_str(NCMD - 3).len());
    err_cmd = 7;

    // No reply to CIPMUX: three attempts then FAIL
    silent_cmd = NCMD - 2;
    base = tx_log.size();
    pulse_restart();
    done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (link_err) done = 1'b1;
    end
    check("t3_link_err_bound", {31'd0, done}, 32'd1);
    check("t3_cipmux_3x", count_idx(base, NCMD - 2), 3 * cmd_str(NCMD - 2).len());
    check("t3_link_up", {31'd0, link_up}, 32'd0);
    check("t3_cmd_idx", {29'd0, cmd_idx}, NCMD - 2);
    k = tx_log.size();
    repeat (300) @(negedge clk);
    check("t3_silent_in_fail", tx_log.size(), k);
    check("t3_err_held", {31'd0, link_err}, 32'd1);
    silent_cmd = 7;

    // Application bytes in READY
    pulse_restart();
    check("t4_link_err_cleared", {31'd0, link_err}, 32'd0);
    wait_link_up("t4", 1'b0);
    base = tx_log.size();
    k = ack_cnt;
    app_data = 8'h41; app_req = 1'b1;
    for (int n = 0; n < 2; n++) begin
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (app_ack) done = 1'b1;
      end
      check($sformatf("t4_ack%0d_bound", n), {31'd0, done}, 32'd1);
      if (n == 0) app_data = 8'h42;
      else        app_req  = 1'b0;
    end
    repeat (40) @(negedge clk);
    check("t4_ack_count", ack_cnt - k, 2);
    check("t4_app_strobes", tx_log.size() - base, 2);
    if (tx_log.size() >= base + 2) begin
      check("t4_byte0", {24'd0, tx_log[base]},     32'h41);
      check("t4_byte1", {24'd0, tx_log[base + 1]}, 32'h42);
    end

    // Restart while a CIPMUX byte is in flight
    pulse_restart();
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (tx_wrsig && int'(cmd_idx) == NCMD - 2) done = 1'b1;
    end
    check("t5_cipmux_bound", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("t5_busy_in_flight", {31'd0, tx_busy}, 32'd1);
    base = tx_log.size();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t5_cmd_idx_cleared", {29'd0, cmd_idx}, 32'd0);
    check("t5_no_strobe", {31'd0, tx_wrsig}, 32'd0);
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (tx_log.size() >= base + 4) done = 1'b1;
    end
    check("t5_resend_bound", {31'd0, done}, 32'd1);
    s = cmd_str(0);
    mism = 0;
    for (int j = 0; j < 4; j++)
      if (tx_log.size() > base + j && (tx_log[base + j] !== s[j] || idx_log[base + j] !== 3'd0))
        mism++;
    check("t5_cmd0_bytes", mism, 0);
    check("t5_protocol", prot_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
